// File: rtl/scon_tx_engine_pkg.sv
// Shared types and frame constants for the SCON serial transmit engine.
package scon_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT     = 2'd0,
        MODE_UART8     = 2'd1,
        MODE_UART9_FIX = 2'd2,
        MODE_UART9_VAR = 2'd3
    } scon_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_NINTH,
        TX_STOP,
        TX_SHIFT
    } tx_state_e;

    localparam int FRAME_BITS_SHIFT = 8;
    localparam int FRAME_BITS_UART8 = 10;
    localparam int FRAME_BITS_UART9 = 11;

    function automatic int frame_bits(input scon_mode_e m);
        case (m)
            MODE_SHIFT: return FRAME_BITS_SHIFT;
            MODE_UART8: return FRAME_BITS_UART8;
            default:    return FRAME_BITS_UART9;
        endcase
    endfunction

endpackage

// File: rtl/scon_tx_engine_if.sv
// SBUF write / status bundle between the SCON register block (master) and the tx engine (slave).
interface scon_tx_engine_if;
    logic       sbuf_wr;
    logic [7:0] sbuf_data;
    logic [1:0] mode;
    logic       tb8;
    logic       tx_busy;
    logic       tx_complete;
    logic       tx_overrun;

    modport master (
        output sbuf_wr, sbuf_data, mode, tb8,
        input  tx_busy, tx_complete, tx_overrun
    );

    modport slave (
        input  sbuf_wr, sbuf_data, mode, tb8,
        output tx_busy, tx_complete, tx_overrun
    );
endinterface

// File: rtl/scon_tx_engine_bit_timer.sv
// Bit-period timer: counts clk (modes 0/2) or baud_tick (modes 1/3) and strobes bit_end.
module scon_tx_bit_timer
    import scon_pkg::*;
#(
    parameter int SHIFT_DIV  = 12,
    parameter int FIXED_DIV  = 64,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  scon_mode_e mode,
    input  logic       baud_tick,
    output logic       bit_end,
    output logic       half
);
    localparam int MAX_A   = (SHIFT_DIV > FIXED_DIV) ? SHIFT_DIV : FIXED_DIV;
    localparam int MAX_DIV = (MAX_A > OVERSAMPLE) ? MAX_A : OVERSAMPLE;
    localparam int CW      = $clog2(MAX_DIV + 1);

    logic [CW-1:0] cnt_q, cnt_d, limit;
    logic          advance;

    always_comb begin
        case (mode)
            MODE_SHIFT:     limit = CW'(SHIFT_DIV);
            MODE_UART9_FIX: limit = CW'(FIXED_DIV);
            default:        limit = CW'(OVERSAMPLE);
        endcase
        advance = run && ((mode == MODE_SHIFT) || (mode == MODE_UART9_FIX) || baud_tick);
        bit_end = advance && (cnt_q == limit - 1'b1);
        cnt_d   = cnt_q;
        if (clear || bit_end) begin
            cnt_d = '0;
        end else if (advance) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Evaluated on the next count so the registered txclk lines up with it.
        half = (cnt_d >= CW'(SHIFT_DIV / 2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/scon_tx_engine.sv
// SCON serial transmit engine: frames an SBUF byte per SM0/SM1 and shifts it out on txd.
// Define SCON_TX_HOLD_EN to add a one-entry holding register for writes made while busy.
module scon_tx_engine
    import scon_pkg::*;
#(
    parameter int SHIFT_DIV  = 12,
    parameter int FIXED_DIV  = 64,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    scon_tx_engine_if.slave  bus,
    input  logic             baud_tick,
    output logic             txd,
    output logic             txclk
);
    tx_state_e  state_q;
    scon_mode_e mode_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] data_q;
    logic       tb8_q;
    logic       txd_q, txclk_q, busy_q, complete_q, overrun_q;

    logic       bit_end, half, frame_last, launch, hold_take, overrun_d;
    logic [7:0] ln_data;
    scon_mode_e ln_mode;
    logic       ln_tb8;

`ifdef SCON_TX_HOLD_EN
    logic       hold_full_q, hold_store;
    logic [7:0] hold_data_q;
    scon_mode_e hold_mode_q;
    logic       hold_tb8_q;
`endif

    scon_tx_bit_timer #(
        .SHIFT_DIV (SHIFT_DIV),
        .FIXED_DIV (FIXED_DIV),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (launch),
        .run      (busy_q),
        .mode     (mode_q),
        .baud_tick(baud_tick),
        .bit_end  (bit_end),
        .half     (half)
    );

    always_comb begin
        ln_data    = bus.sbuf_data;
        ln_mode    = scon_mode_e'(bus.mode);
        ln_tb8     = bus.tb8;
        frame_last = bit_end && (int'(bit_cnt_q) == frame_bits(mode_q) - 1);
`ifdef SCON_TX_HOLD_EN
        if (hold_full_q) begin
            ln_data = hold_data_q;
            ln_mode = hold_mode_q;
            ln_tb8  = hold_tb8_q;
        end
        // A write landing on the last cycle with an empty holder chains straight on.
        hold_take  = frame_last && (hold_full_q || bus.sbuf_wr);
        hold_store = busy_q && bus.sbuf_wr && !hold_full_q && !frame_last;
        overrun_d  = busy_q && bus.sbuf_wr && hold_full_q;
`else
        hold_take  = 1'b0;
        overrun_d  = busy_q && bus.sbuf_wr;
`endif
        launch = (!busy_q && bus.sbuf_wr) || hold_take;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            mode_q     <= MODE_SHIFT;
            bit_cnt_q  <= '0;
            txd_q      <= 1'b1;
            txclk_q    <= 1'b1;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            complete_q <= frame_last;
            overrun_q  <= overrun_d;
            if (launch) begin
                state_q   <= (ln_mode == MODE_SHIFT) ? TX_SHIFT : TX_START;
                mode_q    <= ln_mode;
                bit_cnt_q <= '0;
                busy_q    <= 1'b1;
                txd_q     <= (ln_mode == MODE_SHIFT) ? ln_data[0] : 1'b0;
                txclk_q   <= (ln_mode != MODE_SHIFT);
            end else if (frame_last) begin
                state_q <= TX_IDLE;
                busy_q  <= 1'b0;
                txd_q   <= 1'b1;
                txclk_q <= 1'b1;
            end else begin
                if (bit_end) begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    case (state_q)
                        TX_SHIFT: txd_q <= data_q[1];
                        TX_START: begin
                            state_q <= TX_DATA;
                            txd_q   <= data_q[0];
                        end
                        TX_DATA: begin
                            if (bit_cnt_q == 4'(FRAME_BITS_SHIFT)) begin
                                if (mode_q == MODE_UART8) begin
                                    state_q <= TX_STOP;
                                    txd_q   <= 1'b1;
                                end else begin
                                    state_q <= TX_NINTH;
                                    txd_q   <= tb8_q;
                                end
                            end else begin
                                txd_q <= data_q[1];
                            end
                        end
                        TX_NINTH: begin
                            state_q <= TX_STOP;
                            txd_q   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (state_q == TX_SHIFT) begin
                    txclk_q <= half;
                end
            end
        end
    end

    // Frame payload: loaded on launch, shifted right as each data bit is consumed.
    always_ff @(posedge clk) begin
        if (launch) begin
            data_q <= ln_data;
            tb8_q  <= ln_tb8;
        end else if (bit_end && ((state_q == TX_SHIFT) || (state_q == TX_DATA))) begin
            data_q <= {1'b0, data_q[7:1]};
        end
    end

`ifdef SCON_TX_HOLD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_full_q <= 1'b0;
        end else if (hold_take) begin
            hold_full_q <= 1'b0;
        end else if (hold_store) begin
            hold_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (hold_store) begin
            hold_data_q <= bus.sbuf_data;
            hold_mode_q <= scon_mode_e'(bus.mode);
            hold_tb8_q  <= bus.tb8;
        end
    end
`endif

    assign txd             = txd_q;
    assign txclk           = txclk_q;
    assign bus.tx_busy     = busy_q;
    assign bus.tx_complete = complete_q;
    assign bus.tx_overrun  = overrun_q;
endmodule
